// File: rtl/aether_mem_pkg.sv
// Shared memory-port definitions for the Aether engine: command encoding,
// arbiter state encoding and bulk-transfer requester indices.
package aether_mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'b00,
        MEM_WRITE = 2'b01,
        MEM_READ  = 2'b10
    } mem_cmd_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_XFER  = 2'b01,
        ARB_DRAIN = 2'b10
    } arb_state_t;

    localparam int REQ_LDW = 0;
    localparam int REQ_CNV = 1;
    localparam int REQ_DNS = 2;
    localparam int REQ_LIP = 3;

endpackage

// File: rtl/aether_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the
// priority pointer, returned as a one-hot grant plus a valid flag.
module aether_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               vld_o
);

    logic [PTR_W:0] w_idx;

    always_comb begin
        gnt_o = '0;
        vld_o = 1'b0;
        w_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!vld_o && req_i[w_idx[PTR_W-1:0]]) begin
                gnt_o[w_idx[PTR_W-1:0]] = 1'b1;
                vld_o                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aether_mem_arbiter.sv
// Round-robin owner of the external memory port: sequences burst addresses,
// counts issued and returned beats, and routes write/read data handshakes.
module aether_mem_arbiter
    import aether_mem_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int BURST_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic [NUM_REQ*BURST_W-1:0] req_len_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         wdata_rdy_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [NUM_REQ-1:0]         rdata_vld_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic [1:0]                 mem_cmd_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    input  logic                       mem_rdy_i,
    input  logic [DATA_W-1:0]          mem_rdata_i,
    input  logic                       mem_rvld_i,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = BURST_W + 1;

    arb_state_t          r_state;
    logic [REQ_W-1:0]    r_ptr;
    logic [REQ_W-1:0]    r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [BURST_W-1:0]  r_len;
    logic [CNT_W-1:0]    r_issued;
    logic [CNT_W-1:0]    r_returned;
    logic [NUM_REQ-1:0]  r_done;
    logic                r_err;

    logic [ADDR_W-1:0]   w_addr  [NUM_REQ];
    logic [BURST_W-1:0]  w_len   [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr[gi]  = req_addr_i[gi*ADDR_W +: ADDR_W];
            assign w_len[gi]   = req_len_i[gi*BURST_W +: BURST_W];
            assign w_wdata[gi] = req_wdata_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // A requester whose done_o is showing may still hold req_i this cycle.
    logic [NUM_REQ-1:0]  w_req_eff;
    logic [NUM_REQ-1:0]  w_pick_oh;
    logic                w_pick_vld;
    logic [REQ_W-1:0]    w_pick_idx;

    assign w_req_eff = req_i & ~r_done;

    aether_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (REQ_W)
    ) u_rr (
        .req_i   (w_req_eff),
        .ptr_i   (r_ptr),
        .gnt_o   (w_pick_oh),
        .vld_o   (w_pick_vld)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_pick_oh[k]) w_pick_idx = REQ_W'(k);
        end
    end

    function automatic logic [REQ_W-1:0] f_next_ptr(input logic [REQ_W-1:0] idx);
        return (idx == REQ_W'(NUM_REQ - 1)) ? '0 : idx + REQ_W'(1);
    endfunction

    logic [NUM_REQ-1:0]  w_owner_oh;
    logic                w_xfer;
    logic [CNT_W-1:0]    w_len_p1;
    logic                w_rd_issuing;
    logic                w_issue;
    logic [CNT_W-1:0]    w_issued_next;
    logic                w_ret_ok;
    logic [CNT_W-1:0]    w_returned_next;
    logic                w_complete;
    mem_cmd_t            w_cmd;

    assign w_owner_oh      = NUM_REQ'(1) << r_owner;
    assign w_xfer          = (r_state == ARB_XFER);
    assign w_len_p1        = {1'b0, r_len} + CNT_W'(1);
    assign w_rd_issuing    = w_xfer & ~r_we & (r_issued < w_len_p1);
    assign w_issue         = w_xfer & mem_rdy_i & (r_we | w_rd_issuing);
    assign w_issued_next   = r_issued + CNT_W'(w_issue);
    // Counting against issued_next accepts a return in the same cycle as its issue.
    assign w_ret_ok        = mem_rvld_i & (r_returned < w_issued_next)
                           & ((w_xfer & ~r_we) | (r_state == ARB_DRAIN));
    assign w_returned_next = r_returned + CNT_W'(w_ret_ok);
    assign w_complete      = w_xfer & ~flush_i
                           & ((r_we & w_issue & (r_issued == {1'b0, r_len}))
                           | (~r_we & (w_returned_next == w_len_p1)));

    always_comb begin
        w_cmd = MEM_IDLE;
        if (w_xfer && r_we)  w_cmd = MEM_WRITE;
        else if (w_rd_issuing) w_cmd = MEM_READ;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_returned <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_done     <= '0;
            r_issued   <= w_issued_next;
            r_returned <= w_returned_next;
            if (w_issue) r_addr <= r_addr + ADDR_W'(1);
            if (flush_i) r_err <= 1'b0;
            else if (mem_rvld_i && !w_ret_ok) r_err <= 1'b1;

            case (r_state)
                ARB_IDLE: begin
                    if (!flush_i && w_pick_vld) begin
                        r_state    <= ARB_XFER;
                        r_owner    <= w_pick_idx;
                        r_we       <= req_we_i[w_pick_idx];
                        r_addr     <= w_addr[w_pick_idx];
                        r_len      <= w_len[w_pick_idx];
                        r_issued   <= '0;
                        r_returned <= '0;
                    end
                end
                ARB_XFER: begin
                    if (flush_i) begin
                        r_state <= (!r_we && (w_returned_next != w_issued_next)) ? ARB_DRAIN : ARB_IDLE;
                    end else if (w_complete) begin
                        r_state <= ARB_IDLE;
                        r_done  <= w_owner_oh;
                        r_ptr   <= f_next_ptr(r_owner);
                    end
                end
                ARB_DRAIN: begin
                    if (w_returned_next == r_issued) r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign gnt_o       = w_xfer ? w_owner_oh : '0;
    assign wdata_rdy_o = (w_xfer && r_we && mem_rdy_i) ? w_owner_oh : '0;
    assign rdata_vld_o = (w_xfer && w_ret_ok) ? w_owner_oh : '0;
    assign rdata_o     = mem_rdata_i;
    assign done_o      = r_done;
    assign mem_cmd_o   = w_cmd;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = (w_xfer && r_we) ? w_wdata[r_owner] : '0;
    assign busy_o      = (r_state != ARB_IDLE);
    assign err_o       = r_err;

endmodule

// File: tb/tb_aether_mem_arbiter.sv
// Directed bench for aether_mem_arbiter: a transaction-level model is checked
// against the DUT every cycle, plus literal expectations per scenario.
module tb_aether_mem_arbiter;

    localparam int NR = 4;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int BW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR-1:0]     req_we = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*BW-1:0]  req_len = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR-1:0]     gnt, wrdy, rvld, done;
    logic [DW-1:0]     rdata;
    logic [1:0]        mem_cmd;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_rdy = 1'b0;
    logic [DW-1:0]     mem_rdata = '0;
    logic              mem_rvld = 1'b0;
    logic              busy, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aether_mem_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .req_i       (req),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_len_i   (req_len),
        .req_wdata_i (req_wdata),
        .gnt_o       (gnt),
        .wdata_rdy_o (wrdy),
        .rdata_o     (rdata),
        .rdata_vld_o (rvld),
        .done_o      (done),
        .mem_cmd_o   (mem_cmd),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdy_i   (mem_rdy),
        .mem_rdata_i (mem_rdata),
        .mem_rvld_i  (mem_rvld),
        .busy_o      (busy),
        .err_o       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: burst owner (-1 none), drain flag, beat counters.
    int   m_owner = -1, m_ptr = 0, m_done = -1, m_addr = 0, m_len = 0, m_iss = 0, m_ret = 0;
    bit   m_we = 0, m_drain = 0, m_err = 0;
    // Scenario logs taken from the DUT for the literal checks.
    int          issue_q[$];
    logic [15:0] wd_q[$];
    logic [15:0] rd_q[$];
    int          grant_q[$];
    int          done_cnt[NR];
    int          rvld_cnt[NR];
    int          wrdy_cnt[NR];
    logic [NR-1:0] prev_gnt = '0;

    bit          e_act, e_iss, e_ok;
    int          e_cmd, pd, idx;
    logic [NR-1:0] e_gnt, e_wrdy, e_rvld, e_done;
    logic [DW-1:0] e_wdata;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_gnt", gnt, 0);     chk("rst_busy", busy, 0);
            chk("rst_cmd", mem_cmd, 0); chk("rst_addr", mem_addr, 0);
            chk("rst_wdata", mem_wdata, 0); chk("rst_done", done, 0);
            chk("rst_wrdy", wrdy, 0);   chk("rst_rvld", rvld, 0);
            chk("rst_err", err, 0);     chk("rst_rdata", rdata, 0);
            m_owner = -1; m_ptr = 0; m_done = -1; m_addr = 0; m_len = 0;
            m_iss = 0; m_ret = 0; m_we = 0; m_drain = 0; m_err = 0;
            prev_gnt = '0;
        end else begin
            e_act   = (m_owner >= 0);
            e_gnt   = e_act ? NR'(1 << m_owner) : '0;
            e_cmd   = !e_act ? 0 : (m_we ? 1 : ((m_iss <= m_len) ? 2 : 0));
            e_iss   = (e_cmd != 0) && mem_rdy;
            e_ok    = mem_rvld && ((e_act && !m_we) || m_drain) && (m_ret < m_iss + int'(e_iss));
            e_wrdy  = (e_act && m_we && mem_rdy) ? e_gnt : '0;
            e_rvld  = (e_act && e_ok) ? e_gnt : '0;
            e_done  = (m_done >= 0) ? NR'(1 << m_done) : '0;
            e_wdata = '0;
            if (e_act && m_we) e_wdata = req_wdata[m_owner*DW +: DW];
            chk("gnt", gnt, e_gnt);         chk("busy", busy, e_act || m_drain);
            chk("cmd", mem_cmd, e_cmd);     chk("addr", mem_addr, m_addr);
            chk("wdata", mem_wdata, e_wdata); chk("wrdy", wrdy, e_wrdy);
            chk("rvld", rvld, e_rvld);      chk("rdata", rdata, mem_rdata);
            chk("done", done, e_done);      chk("err", err, m_err);

            if (e_iss) begin issue_q.push_back(int'(mem_addr)); wd_q.push_back(mem_wdata); end
            if (rvld != 0) rd_q.push_back(rdata);
            for (int i = 0; i < NR; i++) begin
                if (gnt[i] && prev_gnt == 0) grant_q.push_back(i);
                if (done[i]) begin
                    done_cnt[i]++;
                    $display("txn done requester=%0d t=%0t", i, $time);
                end
                if (rvld[i]) rvld_cnt[i]++;
                if (wrdy[i]) wrdy_cnt[i]++;
            end
            prev_gnt = gnt;

            pd = m_done;
            m_done = -1;
            if (flush) m_err = 0;
            else if (mem_rvld && !e_ok) m_err = 1;
            if (e_act) begin
                m_iss += int'(e_iss);
                m_ret += int'(e_ok);
                if (e_iss) m_addr = (m_addr + 1) % (1 << AW);
                if (flush) begin
                    if (!m_we && m_ret != m_iss) m_drain = 1;
                    m_owner = -1;
                end else if ((m_we && m_iss == m_len + 1) || (!m_we && m_ret == m_len + 1)) begin
                    m_done  = m_owner;
                    m_ptr   = (m_owner + 1) % NR;
                    m_owner = -1;
                end
            end else if (m_drain) begin
                m_ret += int'(e_ok);
                if (m_ret == m_iss) m_drain = 0;
            end else if (!flush) begin
                for (int k = 0; k < NR; k++) begin
                    idx = (m_ptr + k) % NR;
                    if (m_owner < 0 && req[idx] && idx != pd) begin
                        m_owner = idx;
                        m_we    = req_we[idx];
                        m_addr  = int'(req_addr[idx*AW +: AW]);
                        m_len   = int'(req_len[idx*BW +: BW]);
                        m_iss   = 0;
                        m_ret   = 0;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit we, input int addr, input int len, input int wd);
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = AW'(addr);
        req_len[i*BW +: BW]   = BW'(len);
        req_wdata[i*DW +: DW] = DW'(wd);
    endtask

    task automatic wait_done(input int i, input int budget, input string name);
        bit seen;
        seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            cyc();
            if (done[i]) seen = 1;
            req = req & ~done;
        end
        chk(name, 32'(seen), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    int bi, bw, br, bg, d0, r0, w0;
    bit pat [5] = '{1, 0, 1, 0, 1};
    int nacc;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // Simultaneous single-beat writes, then re-request 0 and 1 after the wrap.
        for (int k = 0; k < NR; k++) set_req(k, 1, 'h100 * k, 0, 'h1000 + k);
        bg = grant_q.size();
        mem_rdy = 1;
        req = 4'b1111;
        wait_done(3, 40, "rr_all_done");
        req = req | 4'b0011;
        wait_done(1, 40, "rr_rereq_done");
        chk("rr_count", grant_q.size() - bg, 6);
        for (int k = 0; k < 6; k++) begin
            int expg [6] = '{0, 1, 2, 3, 0, 1};
            if (bg + k < grant_q.size()) chk("rr_order", grant_q[bg + k], expg[k]);
        end
        cyc();

        // Single read, 4 beats from 0x10, 2-cycle return latency.
        bi = issue_q.size(); br = rd_q.size(); d0 = done_cnt[2]; r0 = rvld_cnt[2];
        set_req(2, 0, 'h10, 3, 0);
        req = 4'b0100;
        cyc(); cyc(); cyc();
        for (int b = 0; b < 4; b++) begin mem_rvld = 1; mem_rdata = 16'hA000 + 16'(b); cyc(); end
        mem_rvld = 0; mem_rdata = 0; req = 0;
        chk("rd_done_pulse", done, 4'b0100);
        cyc(); cyc();
        chk("rd_done_cnt", done_cnt[2] - d0, 1);
        chk("rd_rvld_cnt", rvld_cnt[2] - r0, 4);
        chk("rd_issue_cnt", issue_q.size() - bi, 4);
        for (int b = 0; b < 4; b++) begin
            if (bi + b < issue_q.size()) chk("rd_addr", issue_q[bi + b], 'h10 + b);
            if (br + b < rd_q.size())    chk("rd_data", rd_q[br + b], 'hA000 + b);
        end

        // Write with backpressure 1,0,1,0,1.
        bi = issue_q.size(); w0 = wrdy_cnt[1]; d0 = done_cnt[1];
        set_req(1, 1, 'h200, 2, 'h3000);
        req = 4'b0010; mem_rdy = 0;
        cyc();
        nacc = 0;
        for (int c = 0; c < 5; c++) begin
            mem_rdy = pat[c];
            req_wdata[1*DW +: DW] = 16'h3000 + 16'(nacc);
            cyc();
            if (pat[c]) nacc++;
        end
        mem_rdy = 0; req = 0;
        chk("wr_done_pulse", done, 4'b0010);
        cyc(); cyc();
        chk("wr_wrdy_cnt", wrdy_cnt[1] - w0, 3);
        chk("wr_done_cnt", done_cnt[1] - d0, 1);
        chk("wr_issue_cnt", issue_q.size() - bi, 3);
        for (int b = 0; b < 3; b++) begin
            if (bi + b < issue_q.size()) begin
                chk("wr_addr", issue_q[bi + b], 'h200 + b);
                chk("wr_data", wd_q[bi + b], 'h3000 + b);
            end
        end

        // Address wrap on a zero-latency read.
        bi = issue_q.size(); r0 = rvld_cnt[3];
        set_req(3, 0, 'hFFFFE, 3, 0);
        req = 4'b1000; mem_rdy = 1;
        cyc();
        for (int b = 0; b < 4; b++) begin mem_rvld = 1; mem_rdata = 16'hB000 + 16'(b); cyc(); end
        mem_rvld = 0; mem_rdata = 0; req = 0;
        chk("wrap_done_pulse", done, 4'b1000);
        cyc(); cyc();
        chk("wrap_err", err, 0);
        chk("wrap_rvld_cnt", rvld_cnt[3] - r0, 4);
        begin
            int expa [4] = '{'hFFFFE, 'hFFFFF, 0, 1};
            for (int b = 0; b < 4; b++)
                if (bi + b < issue_q.size()) chk("wrap_addr", issue_q[bi + b], expa[b]);
        end

        // Flush after 5 issued / 2 returned; drain eats the other 3.
        bi = issue_q.size(); r0 = rvld_cnt[0]; d0 = done_cnt[0];
        set_req(0, 0, 'h400, 7, 0);
        req = 4'b0001; mem_rdy = 1;
        cyc(); cyc(); cyc();
        mem_rvld = 1; mem_rdata = 16'hC000; cyc();
        mem_rdata = 16'hC001; cyc();
        mem_rvld = 0; mem_rdata = 0; cyc();
        mem_rdy = 0; flush = 1; req = 0;
        cyc();
        flush = 0;
        chk("fl_busy_drain", busy, 1);
        chk("fl_cmd_drain", mem_cmd, 0);
        for (int b = 0; b < 3; b++) begin mem_rvld = 1; mem_rdata = 16'hD000 + 16'(b); cyc(); end
        mem_rvld = 0; mem_rdata = 0;
        chk("fl_busy_idle", busy, 0);
        chk("fl_err", err, 0);
        cyc();
        chk("fl_done_cnt", done_cnt[0] - d0, 0);
        chk("fl_rvld_cnt", rvld_cnt[0] - r0, 2);
        chk("fl_issue_cnt", issue_q.size() - bi, 5);

        // Stray return in IDLE sets err until flush.
        mem_rvld = 1; mem_rdata = 16'hEEEE; cyc();
        mem_rvld = 0; mem_rdata = 0;
        chk("stray_err_set", err, 1);
        cyc();
        chk("stray_err_hold", err, 1);
        flush = 1; cyc();
        flush = 0;
        chk("stray_err_clr", err, 0);

        // Async reset in the middle of a stalled write burst.
        set_req(2, 1, 'h500, 5, 'h5555);
        req = 4'b0100; mem_rdy = 0;
        cyc(); cyc();
        mem_rvld = 1; cyc();
        mem_rvld = 0;
        chk("ar_busy_pre", busy, 1);
        chk("ar_err_pre", err, 1);
        #2 rst_n = 0; mem_rdy = 1;
        #1;
        chk("ar_busy", busy, 0);     chk("ar_gnt", gnt, 0);
        chk("ar_cmd", mem_cmd, 0);   chk("ar_addr", mem_addr, 0);
        chk("ar_wrdy", wrdy, 0);     chk("ar_err", err, 0);
        chk("ar_wdata", mem_wdata, 0);
        req = 0; mem_rdy = 0;
        @(posedge clk); #1 rst_n = 1;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
